mult_accumulator: RTL

Result-side stage that sits directly downstream of the sequential Booth multiplier. It consumes a stream of signed 2N-bit products over a valid/ready handshake and sums a programmed number of them (a burst) into a guard-extended accumulator. It presents the final sum with a valid/ready handshake and flags signed overflow. It turns the multiplier into the back half of a dot-product / MAC datapath.

---
 rtl/mult_accumulator.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mult_accumulator.sv
// Burst accumulator for signed 2N-bit products with a guard-extended sum and a sticky overflow flag.
// Optional feature: define MULT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module mult_accumulator #(
   parameter int N  = 32,
   parameter int G  = 8,
   parameter int LW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [LW-1:0]        len,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*N-1:0]       in_product,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*N+G-1:0]     out_acc,
   output logic [LW-1:0]        out_count,
   output logic                 ovf,
   output logic                 busy,
   output logic [1:0]           fsm_state
);

   localparam int AW = 2*N+G;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready and valid are decoded from the state register only.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [LW-1:0]   len_q;
   logic [AW-1:0]   acc;
   logic [LW-1:0]   count;
   logic            ovf_q;

   logic            start_ok;
   logic            beat;
   logic            last_beat;
   logic [LW-1:0]   count_inc;
   logic [AW:0]     sum_full;
   logic            ovf_beat;
   logic [AW-1:0]   acc_next;

   assign start_ok  = (state == IDLE) && start && !abort;
   assign beat      = (state == ACCUM) && in_valid && !abort;
   assign count_inc = count + 1'b1;
   assign last_beat = beat && (count_inc == len_q);

   // One extra bit of headroom: the top two bits disagree exactly when the true sum leaves the AW range.
   assign sum_full  = {acc[AW-1], acc} + {{(G+1){in_product[2*N-1]}}, in_product};
   assign ovf_beat  = sum_full[AW] ^ sum_full[AW-1];

`ifdef MULT_ACC_SATURATE_EN
   always_comb begin
      acc_next = sum_full[AW-1:0];
      if (ovf_beat) begin
         if (sum_full[AW])
            acc_next = {1'b1, {(AW-1){1'b0}}};
         else
            acc_next = {1'b0, {(AW-1){1'b1}}};
      end
   end
`else
   assign acc_next = sum_full[AW-1:0];
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0)
                     state_next = ACCUM;
                  else
                     state_next = DONE;
               end
            end
            ACCUM: begin
               if (last_beat)
                  state_next = DONE;
            end
            DONE: begin
               if (out_ready)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE:    ;
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers; abort leaves them untouched because start_ok and beat both exclude it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
         acc   <= '0;
         count <= '0;
         ovf_q <= 1'b0;
      end else if (start_ok) begin
         len_q <= len;
         acc   <= '0;
         count <= '0;
         ovf_q <= 1'b0;
      end else if (beat) begin
         acc   <= acc_next;
         count <= count_inc;
         if (ovf_beat)
            ovf_q <= 1'b1;
      end
   end

   assign out_acc   = acc;
   assign out_count = count;
   assign ovf       = ovf_q;
   assign fsm_state = state;

endmodule
